nibble_serial_add_ctrl: RTL and testbench
=========================================

# nibble_serial_add_ctrl

Sequencer that performs WIDTH-bit additions by time-multiplexing one 4-bit carry-look-ahead slice over WIDTH/4 cycles, least-significant nibble first, with a registered carry between nibbles. It sits between an operand producer and a result consumer using valid/ready handshakes on both sides. It trades latency for area in datapaths where a full-width adder is not justified.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of 4 and at least 4. NIB = WIDTH/4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract request; used only with NSA_SUB_EN, ignored otherwise
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out of the MSB nibble
- ovf  out  1  signed overflow of the result

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: processes one nibble per cycle.
  - DONE: out_valid=1.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from the state register.
- IDLE → RUN on accept (in_valid & in_ready at an edge). On that edge:
  - a, b and the effective B operand are latched.
  - The carry register loads cin.
  - nibble index idx ← 0; sum ← 0.
- RUN, each edge:
  - Slice inputs are nibble idx of the latched A, nibble idx of the latched B and the carry register.
  - The slice sum is written to sum[4*idx+3:4*idx]; the carry register ← slice cout; idx ← idx+1.
  - On the edge where idx==NIB-1, state → DONE, cout ← slice cout, and ovf ← (A[W-1]==B'[W-1]) & (sum[W-1]!=A[W-1]), using the new sum MSB.
- DONE → IDLE on out_valid & out_ready.
- sum, cout and ovf stay stable from DONE entry until the next accept.
- Inputs a, b, cin and sub are ignored outside the accept edge. in_valid during RUN or DONE has no effect.
- idx has width clog2(NIB) with a minimum of 1. With WIDTH=4 (NIB=1), RUN lasts exactly one cycle.
- Arithmetic: sum = (A + B' + c0) mod 2^WIDTH, cout = bit WIDTH of that result. Without subtraction, B' = b and c0 = cin.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry register=0, latched operands=0.
- If the accept happens at edge T, out_valid rises after edge T+NIB.
- The earliest output handshake is edge T+NIB+1. in_ready is high again after that edge, so the earliest next accept is edge T+NIB+2. Peak throughput is one operation per NIB+2 cycles.
- Back-pressure: with out_ready low, the block holds in DONE indefinitely with outputs frozen.
- Reset during RUN or DONE aborts the operation. All outputs take their reset values and no partial result is ever presented.
- No combinational path exists from in_valid or out_ready to any output.

## Configuration
- NSA_SUB_EN defined:
  - When sub=1 at accept, B' = ~b and c0 = 1, so sum = a - b mod 2^WIDTH. cout=1 means no borrow; ovf is signed overflow of the subtraction.
  - When sub=0, behaviour is identical to the undefined case.
- NSA_SUB_EN undefined: the sub port is present but unconnected internally, and B' = b, c0 = cin always.

## Structure
- Package nsa_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - the constant SLICE_W = 4.
- Sub-module cla4_slice: purely combinational 4-bit generate/propagate look-ahead adder (a[3:0], b[3:0], cin → sum[3:0], cout). It is instantiated once. The controller owns all registers.

## Test plan
All scenarios use WIDTH=16 (NIB=4).
1. a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept edge.
2. a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0; the carry ripples through all 4 nibbles.
3. a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, ovf=1, cout=0. Then a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
4. Hold out_ready low for 6 cycles in DONE while toggling in_valid and a → sum stays stable, in_ready stays 0, no accept occurs. out_ready=1 → handshake, then in_ready=1 on the next cycle.
5. Assert rst while idx=2 in RUN → out_valid=0, sum=0, in_ready=1 immediately. A fresh operation afterwards completes correctly.
6. With NSA_SUB_EN defined:
   - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int SLICE_W = 4;

endpackage : nsa_pkg

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-look-ahead adder slice (generate/propagate).
module cla4_slice
   import nsa_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is flattened from g/p/cin so no carry ripples through another.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[SLICE_W-1:0];
   assign cout = c[SLICE_W];

endmodule : cla4_slice

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add sequencer reusing one 4-bit CLA slice, LS nibble first, valid/ready on both sides.
// Define NSA_SUB_EN to honour the sub input (B' = ~b, c0 = 1 when sub is set at accept).
module nibble_serial_add_ctrl
   import nsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIB   = WIDTH / SLICE_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   b_eff;
   logic               c0;
   logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
   logic               sl_cout;

`ifdef NSA_SUB_EN
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign unused_sub = sub;
   assign b_eff      = b;
   assign c0         = cin;
`endif

   assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
   assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

   cla4_slice u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b_eff;
               carry_d = c0;
               idx_d   = '0;
               sum_d   = '0;
            end
         end
         RUN: begin
            sum_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
            carry_d = sl_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               state_d = DONE;
               cout_d  = sl_cout;
               // Overflow needs the freshly written MSB, hence sum_d rather than sum_q.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule : nibble_serial_add_ctrl

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench: directed operations, arithmetic reference model and per-cycle result compare.
module tb_nibble_serial_add_ctrl;

   localparam int W = 16;
`ifdef NSA_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   res_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference: plain wide arithmetic on the operands as the user sees them.
   function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub);
      logic [W:0]   t;
      logic [W-1:0] bb;
      logic         c;
      res_t         r;
      bb = mb;
      c  = mcin;
      if (SUB_EN && msub) begin
         bb = ~mb;
         c  = 1'b1;
      end
      t      = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c};
      r.sum  = t[W-1:0];
      r.cout = t[W];
      r.ovf  = (ma[W-1] == bb[W-1]) && (t[W-1] != ma[W-1]);
      return r;
   endfunction

   // Result compare on every cycle a result is presented; pop when the handshake will complete.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL cmp_unexpected: got out_valid=1, expected 0 (no operation pending)");
         end else begin
            check("cmp_sum", sum, exp_q[0].sum);
            check("cmp_cout", W'(cout), W'(exp_q[0].cout));
            check("cmp_ovf", W'(ovf), W'(exp_q[0].ovf));
            check("cmp_in_ready", W'(in_ready), '0);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_in_ready"}, W'(in_ready), W'(1));
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub, input int hold,
                        input logic [W-1:0] lit_sum, input logic lit_cout, input logic lit_ovf);
      int lat;
      wait_ready(tag);
      a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
      exp_q.push_back(model(ta, tb_v, tcin, tsub));
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      check({tag, "_busy"}, W'(in_ready), '0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, W'(lat), W'(4));
      check({tag, "_sum"}, sum, lit_sum);
      check({tag, "_cout"}, W'(cout), W'(lit_cout));
      check({tag, "_ovf"}, W'(ovf), W'(lit_ovf));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         in_valid = ~in_valid;
         a = W'($urandom);
         check({tag, "_hold_valid"}, W'(out_valid), W'(1));
         check({tag, "_hold_ready"}, W'(in_ready), '0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_post_valid"}, W'(out_valid), '0);
      check({tag, "_post_ready"}, W'(in_ready), W'(1));
   endtask

   initial begin
      #12;
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_out_valid", W'(out_valid), '0);
      check("rst_sum", sum, '0);
      check("rst_cout", W'(cout), '0);
      check("rst_ovf", W'(ovf), '0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
      do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
      do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
      do_op("t3b", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0);
      do_op("t4", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 6, 16'h1001, 1'b0, 1'b0);

      // Abort mid-run: two nibbles written (0x0045), then asynchronous reset.
      wait_ready("t5");
      a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5_partial", sum, 16'h0045);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("t5_rst_valid", W'(out_valid), '0);
      check("t5_rst_sum", sum, '0);
      check("t5_rst_ready", W'(in_ready), W'(1));
      check("t5_rst_cout", W'(cout), '0);
      check("t5_rst_ovf", W'(ovf), '0);
      @(negedge clk);
      rst = 1'b0;
      do_op("t5_fresh", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1, 16'h0000, 1'b1, 1'b0);

`ifdef NSA_SUB_EN
      do_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0);
      do_op("t6b", 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1);
`else
      do_op("t6_nosub", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'h000C, 1'b0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_nibble_serial_add_ctrl
